// File: rtl/arb_pkg.sv
// ==========================================================================
// arb_pkg : shared types, default sizes and helpers for mem_port_arbiter
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

package arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_RD_LAT  = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT     = 2'd2,
        COMPLETE = 2'd3
    } arb_state_e;

    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_picker.sv
// ==========================================================================
// rr_picker : combinational round-robin select, starting after the last grant
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_picker
    import arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_next_o,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_req_o
);

    logic [IDX_W-1:0] idx;

    // Scan last+1 .. last+NUM_REQ with wrap; the last one served is checked last.
    always_comb begin
        gnt_next_o = '0;
        idx        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_i) + k) % NUM_REQ);
            if ((gnt_next_o == '0) && req_i[idx]) begin
                gnt_next_o[idx] = 1'b1;
            end
        end
    end

    assign winner_o  = IDX_W'(onehot_to_idx(32'(gnt_next_o)));
    assign any_req_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ==========================================================================
// mem_port_arbiter : round-robin arbiter sequencing one memory access at a time
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      busy_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    arb_state_e          state_q;
    logic [IDX_W-1:0]    last_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                cmd_we_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i      (req_i),
        .last_i     (last_q),
        .gnt_next_o (pick_gnt),
        .winner_o   (pick_idx),
        .any_req_o  (pick_any)
    );

    assign sel_we    = we_i[pick_idx];
    assign sel_addr  = addr_i[pick_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = wdata_i[pick_idx*DATA_W +: DATA_W];

    // The memory drives valid read data during COMPLETE; forward it while done
    // is high and keep the captured copy afterwards.
    assign rdata_o     = ((state_q == COMPLETE) && !cmd_we_q) ? mem_rdata_i : rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cmd_we_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        gnt_q       <= pick_gnt;
                        last_q      <= pick_idx;
                        cmd_we_q    <= sel_we;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    if (!cmd_we_q && (RD_LAT > 1)) begin
                        cnt_q   <= CNT_W'(RD_LAT - 2);
                        state_q <= WAIT;
                    end else begin
                        done_q  <= gnt_q;
                        state_q <= COMPLETE;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        done_q  <= gnt_q;
                        state_q <= COMPLETE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                COMPLETE: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    if (!cmd_we_q) begin
                        rdata_q <= mem_rdata_i;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ==========================================================================
// tb_mem_port_arbiter : directed and randomized checks against a reference model
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [N-1:0]      req, we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      gnt, done;
    logic [DW-1:0]     rdata, mem_rdata, mem_wdata;
    logic              busy, mem_en, mem_we;
    logic [AW-1:0]     mem_addr;

    logic [N-1:0]      req3, we3;
    logic [N*AW-1:0]   addr3;
    logic [N*DW-1:0]   wdata3;
    logic [N-1:0]      gnt3, done3;
    logic [DW-1:0]     rdata3, mem_rdata3, mem_wdata3;
    logic              busy3, mem_en3, mem_we3;
    logic [AW-1:0]     mem_addr3;

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT1)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt), .done_o(done), .rdata_o(rdata),
        .busy_o(busy), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
        .clk_i(clk), .reset_i(reset), .req_i(req3), .we_i(we3), .addr_i(addr3),
        .wdata_i(wdata3), .gnt_o(gnt3), .done_o(done3), .rdata_o(rdata3),
        .busy_o(busy3), .mem_en_o(mem_en3), .mem_we_o(mem_we3),
        .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3)
    );

    // Latency-1 synchronous memory
    logic [DW-1:0] mem1 [256] = '{default: 8'h00};
    logic [DW-1:0] rd1;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem1[mem_addr] <= mem_wdata;
            else        rd1 <= mem1[mem_addr];
        end
    end
    assign mem_rdata = rd1;

    // Latency-3 read-only memory whose content is addr ^ 0x5A
    logic [DW-1:0] s0, s1, s2;
    always @(posedge clk) begin
        if (mem_en3 && !mem_we3) s0 <= mem_addr3 ^ 8'h5A;
        s1 <= s0;
        s2 <= s1;
    end
    assign mem_rdata3 = s2;

    int n_checks = 0;
    int n_pass   = 0;
    int m_last;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] exp_mem [256] = '{default: 8'h00};
    int grant_log[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0; req3 = '0;
        tick();
        reset = 1'b0;
        m_last  = N - 1;
        m_rdata = '0;
    endtask

    // Cycle-level reference: a transaction occupies grant cycle, done after
    // 1 (write) or LAT1 (read) more cycles, then one idle cycle.
    task automatic run_traffic(input int cycles, input bit all_high, input string tag);
        logic [N-1:0] req_prev;
        int age, lat, w;
        logic [N-1:0] eg;
        logic ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd, er;
        logic [34:0] obs, expv;
        int waits[N];
        bit fin;
        age = -1; lat = 1; eg = '0; ewe = 1'b0; ea = '0; ewd = '0; er = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int c = 0; c < cycles + 8; c++) begin
            req_prev = req;
            tick();
            fin  = 1'b0;
            expv = {8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, m_rdata};
            if (age < 0) begin
                if (req_prev != '0) begin
                    w = -1;
                    for (int k = 1; k <= N; k++)
                        if (w < 0 && req_prev[(m_last + k) % N]) w = (m_last + k) % N;
                    n_checks++;
                    if (waits[w] > N - 1)
                        $display("FAIL %s starvation req%0d waited %0d exp <= %0d", tag, w, waits[w], N - 1);
                    else n_pass++;
                    for (int i = 0; i < N; i++) if (req_prev[i] && i != w) waits[i]++;
                    waits[w] = 0;
                    m_last = w;
                    grant_log.push_back(w);
                    eg  = N'(1) << w;
                    ewe = we[w];
                    ea  = addr[w*AW +: AW];
                    ewd = wdata[w*DW +: DW];
                    lat = ewe ? 1 : LAT1;
                    if (ewe) exp_mem[ea] = ewd;
                    else     er = exp_mem[ea];
                    age = 0;
                    expv = {eg, 4'b0000, 1'b1, 1'b1, ewe, ea, ewd, m_rdata};
                end
            end else if (age < lat) begin
                age++;
                fin = (age == lat);
                if (fin && !ewe) m_rdata = er;
                expv = {eg, fin ? eg : 4'b0000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, m_rdata};
            end else begin
                age = -1;
            end
            obs = {gnt, done, busy, mem_en, mem_we, mem_addr, mem_wdata, rdata};
            n_checks++;
            if (obs !== expv)
                $display("FAIL %s cycle %0d outputs got %h exp %h", tag, c, obs, expv);
            else n_pass++;
            if (c < cycles) begin
                for (int i = 0; i < N; i++) begin
                    if (fin && eg[i]) begin
                        req[i] = all_high || ($urandom_range(0, 1) == 1);
                    end else if (!req[i] && (all_high || $urandom_range(0, 2) == 0)) begin
                        req[i] = 1'b1;
                    end else begin
                        continue;
                    end
                    we[i] = 1'($urandom_range(0, 1));
                    addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
                    wdata[i*DW +: DW] = DW'($urandom_range(0, 255));
                end
            end else begin
                req = '0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = '1; we = '0; addr = '0; wdata = '0;
        req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
        repeat (2) begin
            tick();
            n_checks++;
            if ({gnt, done, mem_en, busy, rdata, busy3} !== '0)
                $display("FAIL reset_outputs got gnt=%b done=%b en=%b busy=%b rdata=%h exp all 0",
                         gnt, done, mem_en, busy, rdata);
            else n_pass++;
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({gnt, mem_en} !== {4'b0001, 1'b1})
            $display("FAIL reset_first_grant got gnt=%b en=%b exp 0001 1", gnt, mem_en);
        else n_pass++;
        req = '0;
        tick();
        n_checks++;
        if (done !== 4'b0001) $display("FAIL dropped_req_done got %b exp 0001", done);
        else n_pass++;
        tick();
        n_checks++;
        if ({busy, gnt} !== 5'b0) $display("FAIL reset_drain got busy=%b gnt=%b exp 0", busy, gnt);
        else n_pass++;
        m_last = 0; m_rdata = '0;
    endtask

    task automatic test_single_write();
        req = 4'b0001; we = 4'b0001;
        addr[0 +: AW] = 8'h10; wdata[0 +: DW] = 8'hA5;
        tick();
        n_checks++;
        if ({gnt, mem_en, mem_we, mem_addr, mem_wdata, done} !== {4'b0001, 1'b1, 1'b1, 8'h10, 8'hA5, 4'b0000})
            $display("FAIL write_issue got gnt=%b en=%b we=%b a=%h d=%h exp 0001 1 1 10 a5",
                     gnt, mem_en, mem_we, mem_addr, mem_wdata);
        else n_pass++;
        tick();
        n_checks++;
        if ({done, mem_en, mem_addr} !== {4'b0001, 1'b0, 8'h00})
            $display("FAIL write_done got done=%b en=%b a=%h exp 0001 0 00", done, mem_en, mem_addr);
        else n_pass++;
        req = '0;
        tick();
        n_checks++;
        if ({busy, gnt, done} !== 9'b0) $display("FAIL write_idle got busy=%b gnt=%b exp 0", busy, gnt);
        else n_pass++;
        exp_mem[8'h10] = 8'hA5;
        m_last = 0;
    endtask

    task automatic test_read_back();
        req = 4'b0100; we = 4'b0000; addr[2*AW +: AW] = 8'h10;
        tick();
        n_checks++;
        if ({gnt, mem_en, mem_we, mem_addr} !== {4'b0100, 1'b1, 1'b0, 8'h10})
            $display("FAIL read_issue got gnt=%b en=%b we=%b a=%h exp 0100 1 0 10", gnt, mem_en, mem_we, mem_addr);
        else n_pass++;
        tick();
        n_checks++;
        if ({done, rdata} !== {4'b0100, 8'hA5})
            $display("FAIL read_done got done=%b rdata=%h exp 0100 a5", done, rdata);
        else n_pass++;
        req = '0;
        tick();
        n_checks++;
        if ({busy, gnt, rdata} !== {1'b0, 4'b0000, 8'hA5})
            $display("FAIL read_hold got busy=%b gnt=%b rdata=%h exp 0 0000 a5", busy, gnt, rdata);
        else n_pass++;
        m_last = 2; m_rdata = 8'hA5;
    endtask

    task automatic test_fairness();
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++) begin
            we[i] = 1'($urandom_range(0, 1));
            addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
            wdata[i*DW +: DW] = DW'($urandom_range(0, 255));
        end
        req = '1;
        run_traffic(20, 1'b1, "fairness");
        n_checks++;
        if (grant_log.size() < 6) $display("FAIL fairness_count got %0d grants exp >= 6", grant_log.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            n_checks++;
            if (grant_log[i] != exp_seq[i])
                $display("FAIL fairness_order[%0d] got %0d exp %0d", i, grant_log[i], exp_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rotation();
        do_reset();
        req = 4'b0010; we = 4'b1011;
        addr[1*AW +: AW] = 8'h41; wdata[1*DW +: DW] = 8'h11;
        tick();
        n_checks++;
        if (gnt !== 4'b0010) $display("FAIL rot_first got gnt=%b exp 0010", gnt);
        else n_pass++;
        tick();
        req = '0;
        tick();
        addr[3*AW +: AW] = 8'h43; wdata[3*DW +: DW] = 8'h33;
        addr[0*AW +: AW] = 8'h40; wdata[0*DW +: DW] = 8'h00;
        req = 4'b1001;
        tick();
        n_checks++;
        if (gnt !== 4'b1000) $display("FAIL rot_pick3 got gnt=%b exp 1000", gnt);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 4'b1000) $display("FAIL rot_done3 got done=%b exp 1000", done);
        else n_pass++;
        req = 4'b0001;
        tick();
        tick();
        n_checks++;
        if (gnt !== 4'b0001) $display("FAIL rot_pick0 got gnt=%b exp 0001", gnt);
        else n_pass++;
        tick();
        req = '0;
        tick();
        exp_mem[8'h41] = 8'h11; exp_mem[8'h43] = 8'h33; exp_mem[8'h40] = 8'h00;
        m_last = 0;
    endtask

    task automatic test_reset_in_wait();
        req3 = 4'b0001; we3 = '0; addr3[0 +: AW] = 8'h20;
        tick();
        n_checks++;
        if ({gnt3, mem_en3, busy3} !== {4'b0001, 1'b1, 1'b1})
            $display("FAIL wait_issue got gnt=%b en=%b busy=%b exp 0001 1 1", gnt3, mem_en3, busy3);
        else n_pass++;
        tick();
        n_checks++;
        if ({gnt3, mem_en3, busy3, done3} !== {4'b0001, 1'b0, 1'b1, 4'b0000})
            $display("FAIL wait_state got gnt=%b en=%b busy=%b done=%b", gnt3, mem_en3, busy3, done3);
        else n_pass++;
        reset = 1'b1; req3 = '0;
        tick();
        n_checks++;
        if ({gnt3, done3, busy3, mem_en3, mem_addr3} !== '0)
            $display("FAIL wait_abort got gnt=%b done=%b busy=%b en=%b exp 0", gnt3, done3, busy3, mem_en3);
        else n_pass++;
        reset = 1'b0;
        req3 = 4'b0010; addr3[1*AW +: AW] = 8'h33;
        tick();
        n_checks++;
        if ({gnt3, mem_en3, mem_addr3, done3} !== {4'b0010, 1'b1, 8'h33, 4'b0000})
            $display("FAIL wait_regrant got gnt=%b en=%b a=%h done=%b exp 0010 1 33 0", gnt3, mem_en3, mem_addr3, done3);
        else n_pass++;
        repeat (2) begin
            tick();
            n_checks++;
            if (done3 !== 4'b0000) $display("FAIL wait_early_done got %b exp 0000", done3);
            else n_pass++;
        end
        tick();
        n_checks++;
        if ({done3, rdata3} !== {4'b0010, 8'h69})
            $display("FAIL wait_read got done=%b rdata=%h exp 0010 69", done3, rdata3);
        else n_pass++;
        req3 = '0;
        tick();
        n_checks++;
        if ({busy3, rdata3} !== {1'b0, 8'h69})
            $display("FAIL wait_idle got busy=%b rdata=%h exp 0 69", busy3, rdata3);
        else n_pass++;
        m_last = N - 1; m_rdata = '0;
    endtask

    task automatic test_random();
        run_traffic(400, 1'b0, "random");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_back();
        test_fairness();
        test_rotation();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
